// File: rtl/banda_frame_collector.sv
// Serial-to-parallel frame collector: gathers 5 sensor bits MSB first, presents them on a..e
// with a one-cycle load pulse, flags stalled frames. Optional parity bit check: PARITY_CHECK_EN.
module banda_frame_collector #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             e,
  output logic             load,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] frames
);

  // state   | meaning
  // IDLE    | waiting for start; bit_valid ignored
  // COLLECT | shifting in data bits, stall timer running
  // CHECK   | waiting for parity bit (PARITY_CHECK_EN only)
  // DONE    | one cycle: a..e hold the new frame, load high
`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CHECK, S_DONE} state_t;
  localparam int SH_W = 5;
`else
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;
  localparam int SH_W = 4;
`endif

  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT);

  state_t           state, state_n;
  logic [2:0]       idx;
  logic [7:0]       tmo;
  logic [SH_W-1:0]  shadow;
  logic [4:0]       data;
  logic             err_q;
  logic [CNT_W-1:0] frames_q;

  logic             restart;
  logic             accept;
  logic             idle_tick;
  logic             fault;
  logic             deliver;
  logic [4:0]       deliver_data;

  always_comb begin
    state_n      = state;
    restart      = 1'b0;
    accept       = 1'b0;
    idle_tick    = 1'b0;
    fault        = 1'b0;
    deliver      = 1'b0;
`ifdef PARITY_CHECK_EN
    deliver_data = shadow;
`else
    deliver_data = {shadow, bit_in};
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          restart = 1'b1;
          state_n = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (start) begin
          restart = 1'b1;
        end else if (bit_valid) begin
          accept = 1'b1;
          if (idx == 3'd4) begin
`ifdef PARITY_CHECK_EN
            state_n = S_CHECK;
`else
            deliver = 1'b1;
            state_n = S_DONE;
`endif
          end
        end else begin
          idle_tick = 1'b1;
          if (tmo == 8'd1) begin
            fault   = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
`ifdef PARITY_CHECK_EN
      S_CHECK: begin
        if (start) begin
          restart = 1'b1;
          state_n = S_COLLECT;
        end else if (bit_valid) begin
          // even parity: data bits plus parity bit must XOR to zero
          if (^{shadow, bit_in}) begin
            fault   = 1'b1;
            state_n = S_IDLE;
          end else begin
            deliver = 1'b1;
            state_n = S_DONE;
          end
        end else begin
          idle_tick = 1'b1;
          if (tmo == 8'd1) begin
            fault   = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
`endif
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Stall timer counts down from TIMEOUT; expiry is the idle cycle that finds it at 1.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      idx    <= 3'd0;
      tmo    <= 8'd0;
      shadow <= '0;
    end else if (restart) begin
      idx <= 3'd0;
      tmo <= TMO_LOAD;
    end else if (accept) begin
`ifdef PARITY_CHECK_EN
      shadow <= {shadow[3:0], bit_in};
`else
      shadow <= {shadow[2:0], bit_in};
`endif
      idx    <= idx + 3'd1;
      tmo    <= TMO_LOAD;
    end else if (idle_tick) begin
      tmo <= tmo - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      data     <= 5'd0;
      err_q    <= 1'b0;
      frames_q <= '0;
    end else begin
      if (restart) begin
        err_q <= 1'b0;
      end else if (fault) begin
        err_q <= 1'b1;
      end
      if (deliver) begin
        data     <= deliver_data;
        frames_q <= frames_q + CNT_W'(1);
      end
    end
  end

  assign {a, b, c, d, e} = data;
  assign load   = (state == S_DONE);
  assign busy   = (state != S_IDLE);
  assign err    = err_q;
  assign frames = frames_q;

endmodule

// File: tb/tb_banda_frame_collector.sv
// Directed bench for banda_frame_collector with a queue-based frame model checked every cycle.
module tb_banda_frame_collector;

  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 8;

  logic clk = 1'b0;
  logic clear = 1'b0;
  logic start = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_in = 1'b0;
  logic a, b, c, d, e, load, busy, err;
  logic [CNT_W-1:0] frames;

  int checks = 0;
  int errors = 0;

  banda_frame_collector #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .clear(clear), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .load(load), .busy(busy), .err(err), .frames(frames)
  );

  always #5 clk = ~clk;

  // Model: a frame is a queue of accepted bits; delivery and faults follow from its length.
  logic       q[$];
  int         idle_cnt;
  bit         m_busy, m_done, m_load, m_err;
  logic [4:0] m_data;
  int         m_frames;

  task automatic deliver_frame();
    for (int i = 0; i < 5; i++) m_data[4-i] = q[i];
    m_frames = (m_frames + 1) % (1 << CNT_W);
    m_load   = 1'b1;
    m_done   = 1'b1;
  endtask

  always @(posedge clk or posedge clear) begin
    if (clear) begin
      q.delete();
      idle_cnt = 0;
      m_busy = 0; m_done = 0; m_load = 0; m_err = 0;
      m_data = 5'd0;
      m_frames = 0;
    end else begin
      m_load = 1'b0;
      if (m_done) begin
        m_done = 1'b0;
        m_busy = 1'b0;
      end else if (start) begin
        m_busy = 1'b1;
        q.delete();
        idle_cnt = 0;
        m_err = 1'b0;
      end else if (m_busy) begin
        if (bit_valid) begin
          idle_cnt = 0;
          if (q.size() < 5) begin
            q.push_back(bit_in);
`ifndef PARITY_CHECK_EN
            if (q.size() == 5) deliver_frame();
`endif
          end else begin
            int ones;
            ones = int'(bit_in);
            foreach (q[i]) ones += int'(q[i]);
            if (ones % 2 == 0) deliver_frame();
            else begin m_err = 1'b1; m_busy = 1'b0; end
          end
        end else begin
          idle_cnt++;
          if (idle_cnt == TIMEOUT) begin
            m_err = 1'b1;
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    chk("abcde", int'({a, b, c, d, e}), int'(m_data));
    chk("load", int'(load), int'(m_load));
    chk("busy", int'(busy), int'(m_busy));
    chk("err", int'(err), int'(m_err));
    chk("frames", int'(frames), m_frames);
  endtask

  // Leaves the DUT in its DONE cycle on return.
  task automatic send_frame(input logic [4:0] v);
    start = 1'b1;
    cyc();
    start = 1'b0;
    bit_valid = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      bit_in = v[i];
      cyc();
    end
`ifdef PARITY_CHECK_EN
    bit_in = ^v;
    cyc();
`endif
    bit_valid = 1'b0;
  endtask

  initial begin
    logic [4:0] v;
    logic [4:0] bits3;
    logic [4:0] bits01001;
    #1 clear = 1'b1;
    cyc();
    cyc();
    clear = 1'b0;
    chk("reset_abcde", int'({a, b, c, d, e}), 0);
    chk("reset_flags", int'({load, busy, err}), 0);
    chk("reset_frames", int'(frames), 0);
    cyc();

    // start with a simultaneous bit_valid: the bit must be discarded
    start = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
    cyc();
    start = 1'b0;
    v = 5'b10110;
    for (int i = 4; i >= 0; i--) begin bit_in = v[i]; cyc(); end
`ifdef PARITY_CHECK_EN
    bit_in = 1'b1;
    cyc();
`endif
    bit_valid = 1'b0;
    chk("f1_load", int'(load), 1);
    chk("f1_data", int'({a, b, c, d, e}), 5'b10110);
    chk("f1_frames", int'(frames), 1);
    cyc();
    chk("f1_busy_after", int'(busy), 0);

    // stall after 3 bits
    start = 1'b1;
    cyc();
    start = 1'b0;
    bit_valid = 1'b1;
    bits3 = 5'b00101;
    for (int i = 2; i >= 0; i--) begin bit_in = bits3[i]; cyc(); end
    bit_valid = 1'b0;
    repeat (TIMEOUT - 1) cyc();
    chk("tmo_pre_err", int'(err), 0);
    chk("tmo_pre_busy", int'(busy), 1);
    cyc();
    chk("tmo_err", int'(err), 1);
    chk("tmo_busy", int'(busy), 0);
    chk("tmo_data_kept", int'({a, b, c, d, e}), 5'b10110);
    chk("tmo_frames", int'(frames), 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("err_cleared", int'(err), 0);

    // restart mid-frame, with a discarded bit on the restart cycle
    bit_valid = 1'b1;
    bit_in = 1'b1; cyc();
    bit_in = 1'b1; cyc();
    start = 1'b1; bit_in = 1'b1;
    cyc();
    start = 1'b0;
    bits01001 = 5'b01001;
    for (int i = 4; i >= 0; i--) begin bit_in = bits01001[i]; cyc(); end
`ifdef PARITY_CHECK_EN
    bit_in = 1'b0;
    cyc();
`endif
    bit_valid = 1'b0;
    chk("rs_load", int'(load), 1);
    chk("rs_data", int'({a, b, c, d, e}), 5'b01001);
    chk("rs_frames", int'(frames), 2);
    cyc();

    // async clear mid-collect
    start = 1'b1; cyc(); start = 1'b0;
    bit_valid = 1'b1; bit_in = 1'b1; cyc(); cyc();
    bit_valid = 1'b0;
    clear = 1'b1;
    #1;
    chk("clr_data", int'({a, b, c, d, e}), 0);
    chk("clr_flags", int'({load, busy, err}), 0);
    chk("clr_frames", int'(frames), 0);
    cyc();
    clear = 1'b0;
    cyc();

    // start during DONE is ignored
    send_frame(5'b11011);
    chk("done_data", int'({a, b, c, d, e}), 5'b11011);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("done_start_ignored", int'(busy), 0);
    cyc();
    chk("done_still_idle", int'(busy), 0);

    // frame counter wrap
    for (int n = 2; n <= 256; n++) begin
      v = 5'($urandom_range(0, 31));
      send_frame(v);
      chk("wrap_data", int'({a, b, c, d, e}), int'(v));
      if (n == 255) chk("frames_255", int'(frames), 255);
      if (n == 256) chk("frames_wrap", int'(frames), 0);
      cyc();
    end

`ifdef PARITY_CHECK_EN
    start = 1'b1; cyc(); start = 1'b0;
    bit_valid = 1'b1;
    v = 5'b10110;
    for (int i = 4; i >= 0; i--) begin bit_in = v[i]; cyc(); end
    bit_in = 1'b0;
    cyc();
    bit_valid = 1'b0;
    chk("par_err", int'(err), 1);
    chk("par_no_load", int'(load), 0);
    chk("par_frames", int'(frames), 0);
    cyc();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
